stream_demux_n: RTL and testbench

Parametrised 1-to-N streaming demultiplexer. It routes a valid/ready input stream to one of CHANNELS registered output channels, chosen by a select value. The select is latched on the first beat of a packet and held until the last beat, so packets are never split across channels. Beats with an out-of-range select are discarded and counted. It sits between a single producer and N independent consumers on the studie datapath.

---
 rtl/stream_demux_n.sv | 121 ++++++++++++
 tb/tb_stream_demux_n.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// 1-to-N valid/ready demultiplexer: the select is locked for a whole packet,
// each channel has a one-entry output register, and out-of-range beats are dropped and counted.

module stream_demux_n_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             lin,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last
);
   // An empty slot always shows zero data, so a drain clears the payload too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
         last  <= lin;
      end else if (valid && ready) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end
   end
endmodule

module stream_demux_n #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_last,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_last,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic                      busy,
   output logic [CNT_W-1:0]          drop_cnt
);
   typedef enum logic {IDLE, PKT} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d, tgt;
   logic [CHANNELS-1:0] hit, free, load;
   logic               legal, accept, drop;

   assign tgt = (state_q == PKT) ? sel_q : in_sel;

   // hit is one-hot on the target; an all-zero hit means the select is out of range.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      assign hit[c]  = (tgt == SEL_W'(c));
      assign free[c] = !out_valid[c] || out_ready[c];
      assign load[c] = accept && hit[c];

      stream_demux_n_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[c]),
         .din   (in_data),
         .lin   (in_last),
         .ready (out_ready[c]),
         .valid (out_valid[c]),
         .data  (out_data[c*WIDTH +: WIDTH]),
         .last  (out_last[c])
      );
   end

   assign legal    = |hit;
   assign in_ready = !legal || |(hit & free);
   assign accept   = in_valid && in_ready;
   assign drop     = accept && !legal;
   assign busy     = (state_q == PKT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // Framing follows accepted beats regardless of legality, so an illegal packet is dropped whole.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      if (accept) begin
         case (state_q)
            IDLE: if (!in_last) begin
               state_d = PKT;
               sel_d   = in_sel;
            end
            PKT: if (in_last) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (drop && (drop_cnt != {CNT_W{1'b1}}))
         drop_cnt <= drop_cnt + 1'b1;
   end
endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: table of routed beats, per-channel scoreboard queues,
// hand sequences for stall, drop/saturation and mid-packet reset.

module tb_stream_demux_n;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_last, in_valid, in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_last, out_valid, out_ready;
   logic        busy;
   logic [7:0]  drop_cnt;

   logic [7:0]  i3_data;
   logic [1:0]  i3_sel;
   logic        i3_last, i3_valid, i3_ready;
   logic [23:0] o3_data;
   logic [2:0]  o3_last, o3_valid, o3_ready;
   logic        busy3;
   logic [1:0]  drop_cnt3;

   int checks = 0;
   int errors = 0;

   typedef struct packed {logic [7:0] data; logic last;} beat_t;
   typedef struct {logic [1:0] sel; logic [7:0] data; logic last; int exp_ch; logic exp_busy;} vec_t;

   beat_t sbq[4][$];
   vec_t  tbl[8];

   always #5 clk = ~clk;

   stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .drop_cnt(drop_cnt)
   );

   stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(i3_data), .in_sel(i3_sel), .in_last(i3_last),
      .in_valid(i3_valid), .in_ready(i3_ready), .out_data(o3_data), .out_last(o3_last),
      .out_valid(o3_valid), .out_ready(o3_ready), .busy(busy3), .drop_cnt(drop_cnt3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Drives one beat at posedge+1 that must be accepted at the next edge.
   task automatic beat(input vec_t v);
      beat_t b;
      in_valid = 1'b1;
      in_sel   = v.sel;
      in_data  = v.data;
      in_last  = v.last;
      b.data   = v.data;
      b.last   = v.last;
      if (v.exp_ch >= 0) sbq[v.exp_ch].push_back(b);
      @(negedge clk);
      chk("in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy", busy, v.exp_busy);
      if (v.exp_ch >= 0) chk("vld_tgt", out_valid[v.exp_ch], 1);
   endtask

   // Output monitor: pop on every handshake, empty slots must read zero.
   always @(negedge clk) begin
      beat_t e;
      for (int c = 0; c < 4; c++) begin
         if (out_valid[c] && out_ready[c]) begin
            if (sbq[c].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat ch=%0d data=%0h @%0t", c, out_data[c*8 +: 8], $time);
            end else begin
               e = sbq[c].pop_front();
               chk($sformatf("sb_ch%0d", c), {23'd0, out_last[c], out_data[c*8 +: 8]}, {23'd0, e.last, e.data});
            end
         end else if (!out_valid[c]) begin
            chk($sformatf("idle_zero_ch%0d", c), {23'd0, out_last[c], out_data[c*8 +: 8]}, 0);
         end
      end
   end

   initial begin
      tbl[0] = '{2'd2, 8'hA5, 1'b1, 2, 1'b0};
      tbl[1] = '{2'd1, 8'h11, 1'b0, 1, 1'b1};
      tbl[2] = '{2'd3, 8'h22, 1'b0, 1, 1'b1};
      tbl[3] = '{2'd3, 8'h33, 1'b1, 1, 1'b0};
      tbl[4] = '{2'd0, 8'h44, 1'b1, 0, 1'b0};
      tbl[5] = '{2'd3, 8'h55, 1'b0, 3, 1'b1};
      tbl[6] = '{2'd0, 8'h66, 1'b1, 3, 1'b0};
      tbl[7] = '{2'd1, 8'h77, 1'b1, 1, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0; out_ready = 4'hF;
      i3_valid = 1'b0; i3_sel = '0; i3_data = '0; i3_last = 1'b0; o3_ready = 3'h7;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Routing table: one beat per cycle, all consumers ready.
      for (int i = 0; i < 8; i++) begin
         beat(tbl[i]);
         chk($sformatf("mask_%0d", i), out_valid, 32'd1 << tbl[i].exp_ch);
      end
      @(posedge clk); #1;

      // Stall on channel 0: second beat waits, then loads on the drain edge.
      out_ready = 4'b1110;
      beat('{2'd0, 8'hC3, 1'b0, 0, 1'b1});
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h3C; in_last = 1'b1;
      sbq[0].push_back(9'h079);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_data", out_data[7:0], 8'hC3);
         chk("stall_vld", out_valid[0], 1);
      end
      @(posedge clk); #1;
      out_ready = 4'hF;
      @(negedge clk);
      chk("resume_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("reload_vld", out_valid[0], 1);
      chk("reload_data", out_data[7:0], 8'h3C);
      chk("reload_busy", busy, 0);
      @(posedge clk); #1;

      // Channel 0 blocked while channel 2 streams at full rate.
      out_ready = 4'b1110;
      beat('{2'd0, 8'h5A, 1'b1, 0, 1'b0});
      for (int i = 0; i < 4; i++) beat('{2'd2, 8'(8'h80 + i), 1'b1, 2, 1'b0});
      chk("ch0_held", out_data[7:0], 8'h5A);
      out_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1;

      // Illegal select on a 3-channel instance; 2-bit counter saturates.
      for (int i = 0; i < 5; i++) begin
         i3_valid = 1'b1; i3_sel = 2'd3; i3_data = 8'(i); i3_last = (i != 0);
         @(negedge clk);
         chk("drop_in_ready", i3_ready, 1);
         chk("drop_no_vld", o3_valid, 0);
         @(posedge clk); #1;
         chk($sformatf("drop_cnt_%0d", i), drop_cnt3, (i + 1 > 3) ? 3 : i + 1);
         if (i == 0) chk("drop_busy", busy3, 1);
      end
      i3_sel = 2'd1; i3_data = 8'h9E; i3_last = 1'b1;
      @(posedge clk); #1;
      i3_valid = 1'b0;
      chk("ch3_legal_vld", o3_valid, 3'b010);
      chk("ch3_legal_data", o3_data[15:8], 8'h9E);
      chk("ch3_drop_hold", drop_cnt3, 3);

      // Asynchronous reset in the middle of a packet with a stalled output.
      out_ready = 4'b1101;
      beat('{2'd1, 8'hE1, 1'b0, 1, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_drop3", drop_cnt3, 0);
      chk("arst_vld3", o3_valid, 0);
      sbq[1].delete();
      @(negedge clk); #1 rst_n = 1'b1;
      out_ready = 4'hF;
      @(posedge clk); #1;
      beat('{2'd3, 8'hF0, 1'b0, 3, 1'b1});
      beat('{2'd0, 8'h0F, 1'b1, 3, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) chk($sformatf("sb_empty_%0d", c), sbq[c].size(), 0);
      chk("main_drop_cnt", drop_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
